// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_event_pkg
// Description : Shared types and defaults for the key panel front end.
//               Holds the repeat-state encoding, the default timing
//               constants and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package key_event_pkg;

    // Auto-repeat state of one key channel
    typedef enum logic [1:0] {
        RP_IDLE   = 2'd0,
        RP_DELAY  = 2'd1,
        RP_REPEAT = 2'd2
    } rp_state_t;

    // Board defaults: 50 MHz clock, 1 ms tick
    localparam int c_DEF_N_KEYS          = 5;
    localparam int c_DEF_TICK_DIV        = 50000;
    localparam int c_DEF_DEBOUNCE_MS     = 20;
    localparam int c_DEF_REPEAT_DELAY_MS = 500;
    localparam int c_DEF_REPEAT_RATE_MS  = 100;

    // Bits needed to hold every value 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_gen_if
// Description : Key panel bundle: raw active-low pins in, debounced levels
//               and single-cycle event pulses out.
//   key_n       raw pins, 0 = pressed
//   key_level   debounced state, 1 = pressed
//   key_press   one-cycle pulse per accepted press
//   key_release one-cycle pulse per accepted release
//   key_repeat  one-cycle auto-repeat pulse while held
//   tick_1ms    shared 1 ms timebase pulse
//   slave  : the key front end (drives the outputs)
//   master : the panel/consumer side (drives the pins)
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_gen_if #(
    parameter int N_KEYS = 5
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_repeat;
    logic              tick_1ms;

    modport slave (
        input  key_n,
        output key_level, key_press, key_release, key_repeat, tick_1ms
    );

    modport master (
        output key_n,
        input  key_level, key_press, key_release, key_repeat, tick_1ms
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_ch
// Description : One key channel: 2-flop synchroniser, tick-based debounce,
//               registered press/release pulses and auto-repeat FSM.
//   clk, rst     clock, asynchronous active-high reset
//   tick         shared 1 ms tick (one clk cycle wide)
//   key_n        raw active-low pin
//   key_level    debounced level, 1 = pressed
//   key_press    pulse in the cycle key_level rises
//   key_release  pulse in the cycle key_level falls
//   key_repeat   auto-repeat pulse while held
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_MS     = c_DEF_DEBOUNCE_MS,
    parameter int REPEAT_DELAY_MS = c_DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_RATE_MS  = c_DEF_REPEAT_RATE_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int c_DBW = cnt_width(DEBOUNCE_MS);
    localparam int c_RP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                 : REPEAT_RATE_MS;
    localparam int c_RPW = cnt_width(c_RP_MAX);

    localparam logic [c_DBW-1:0] c_DB_LAST    = c_DBW'(DEBOUNCE_MS - 1);
    localparam logic [c_RPW-1:0] c_DELAY_LAST = c_RPW'(REPEAT_DELAY_MS - 1);
    localparam logic [c_RPW-1:0] c_RATE_LAST  = c_RPW'(REPEAT_RATE_MS - 1);

    // Synchroniser holds the already-inverted pin so that the reset value
    // of 0 reads as "released".
    logic r_meta;
    logic r_sync;

    logic [c_DBW-1:0] r_db_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    rp_state_t        r_state,  w_state_next;
    logic [c_RPW-1:0] r_rp_cnt, w_rp_cnt_next;
    logic             r_repeat, w_repeat_next;

    logic w_accept;
    logic w_acc_press;
    logic w_acc_release;

    // A level change is accepted on the tick that would bring the count
    // to DEBOUNCE_MS; any cycle with sync == level restarts the count.
    assign w_accept      = (r_sync != r_level) && tick && (r_db_cnt == c_DB_LAST);
    assign w_acc_press   = w_accept && !r_level;
    assign w_acc_release = w_accept &&  r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_meta <= ~key_n;
            r_sync <= r_meta;

            if (r_sync == r_level) begin
                r_db_cnt <= '0;
            end else if (tick) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DBW'(1);
                end
            end

            if (w_accept) begin
                r_level <= ~r_level;
            end
            r_press   <= w_acc_press;
            r_release <= w_acc_release;
        end
    end

    // Repeat FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RP_IDLE;
            r_rp_cnt <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rp_cnt <= w_rp_cnt_next;
            r_repeat <= w_repeat_next;
        end
    end

    // Repeat FSM: next state. A release accepted in the same cycle as a due
    // repeat wins, so that repeat is never issued.
    always_comb begin
        w_state_next  = r_state;
        w_rp_cnt_next = r_rp_cnt;
        w_repeat_next = 1'b0;
        if (w_acc_release) begin
            w_state_next  = RP_IDLE;
            w_rp_cnt_next = '0;
        end else begin
            case (r_state)
                RP_IDLE: begin
                    if (w_acc_press) begin
                        w_state_next  = RP_DELAY;
                        w_rp_cnt_next = '0;
                    end
                end
                RP_DELAY: begin
                    if (tick) begin
                        if (r_rp_cnt == c_DELAY_LAST) begin
                            w_repeat_next = 1'b1;
                            w_rp_cnt_next = '0;
                            w_state_next  = RP_REPEAT;
                        end else begin
                            w_rp_cnt_next = r_rp_cnt + c_RPW'(1);
                        end
                    end
                end
                RP_REPEAT: begin
                    if (tick) begin
                        if (r_rp_cnt == c_RATE_LAST) begin
                            w_repeat_next = 1'b1;
                            w_rp_cnt_next = '0;
                        end else begin
                            w_rp_cnt_next = r_rp_cnt + c_RPW'(1);
                        end
                    end
                end
                default: begin
                    w_state_next  = RP_IDLE;
                    w_rp_cnt_next = '0;
                end
            endcase
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_event_gen
// Description : Key panel front end. Shared 1 ms prescaler plus N_KEYS
//               independent debounce/auto-repeat channels.
//   clk, rst  clock, asynchronous active-high reset
//   bus       key_event_gen_if slave: key_n in; key_level, key_press,
//             key_release, key_repeat, tick_1ms out (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int N_KEYS          = c_DEF_N_KEYS,
    parameter int TICK_DIV        = c_DEF_TICK_DIV,
    parameter int DEBOUNCE_MS     = c_DEF_DEBOUNCE_MS,
    parameter int REPEAT_DELAY_MS = c_DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_RATE_MS  = c_DEF_REPEAT_RATE_MS
) (
    input logic           clk,
    input logic           rst,
    key_event_gen_if.slave bus
);

    localparam int c_PW = cnt_width(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICK_DIV - 1);

    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_next;
    logic            r_tick;

    logic [N_KEYS-1:0] w_level;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_release;
    logic [N_KEYS-1:0] w_repeat;

    assign w_presc_next = (r_presc == c_PRESC_LAST) ? '0 : r_presc + c_PW'(1);

    // tick is registered from the next counter value so it is high exactly
    // while the counter holds TICK_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_next;
            r_tick  <= (w_presc_next == c_PRESC_LAST);
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce_ch #(
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (r_tick),
            .key_n       (bus.key_n[g]),
            .key_level   (w_level[g]),
            .key_press   (w_press[g]),
            .key_release (w_release[g]),
            .key_repeat  (w_repeat[g])
        );
    end

    assign bus.key_level   = w_level;
    assign bus.key_press   = w_press;
    assign bus.key_release = w_release;
    assign bus.key_repeat  = w_repeat;
    assign bus.tick_1ms    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_gen
// Description : Self-checking bench for key_event_gen with TICK_DIV=4,
//               DEBOUNCE_MS=3, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2.
//               Cycle numbers count rising edges since the last reset
//               release; ticks are consumed on edges 4,8,12,...
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_gen;

    localparam int NK = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_event_gen_if #(.N_KEYS(NK)) bus ();

    key_event_gen #(
        .N_KEYS          (NK),
        .TICK_DIV        (4),
        .DEBOUNCE_MS     (3),
        .REPEAT_DELAY_MS (5),
        .REPEAT_RATE_MS  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          ph;
        int          cyc;
        logic [NK-1:0] key_n;
    } stim_t;

    // Expected pulses at cyc, cyc+per, ... (cnt occurrences)
    typedef struct {
        int          ph;
        int          cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] rep;
        int          cnt;
        int          per;
    } ev_t;

    typedef struct {
        int          ph;
        int          cyc;
        logic [NK-1:0] level;
    } lvl_t;

    stim_t stim[$];
    ev_t   evs[$];
    lvl_t  lvls[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int phase  = 0;
    bit mon_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Per-cycle monitor: any pulse not listed in the event table is an error
    always @(posedge clk) begin
        #1;
        if (mon_en && !rst) begin : mon_body
            logic [NK-1:0] ep, er, eq;
            logic          et;
            ep = '0; er = '0; eq = '0;
            foreach (evs[i]) begin
                if (evs[i].ph == phase) begin
                    for (int k = 0; k < evs[i].cnt; k++) begin
                        if (evs[i].cyc + k * evs[i].per == cyc) begin
                            ep = ep | evs[i].press;
                            er = er | evs[i].rel;
                            eq = eq | evs[i].rep;
                        end
                    end
                end
            end
            checks++;
            if ({bus.key_press, bus.key_release, bus.key_repeat} !== {ep, er, eq}) begin
                errors++;
                $display("FAIL pulses ph=%0d cyc=%0d got press=%b release=%b repeat=%b want press=%b release=%b repeat=%b",
                         phase, cyc, bus.key_press, bus.key_release, bus.key_repeat, ep, er, eq);
            end
            et = ((cyc % 4) == 3);
            checks++;
            if (bus.tick_1ms !== et) begin
                errors++;
                $display("FAIL tick ph=%0d cyc=%0d got %b want %b", phase, cyc, bus.tick_1ms, et);
            end
            foreach (lvls[i]) begin
                if (lvls[i].ph == phase && lvls[i].cyc == cyc) begin
                    checks++;
                    if (bus.key_level !== lvls[i].level) begin
                        errors++;
                        $display("FAIL level ph=%0d cyc=%0d got %b want %b",
                                 phase, cyc, bus.key_level, lvls[i].level);
                    end
                end
            end
        end
    end

    task automatic wait_until(input int c);
        int n;
        n = 0;
        while (cyc != c && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != c) begin
            checks++;
            errors++;
            $display("FAIL wait_cycle got %0d want %0d", cyc, c);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({bus.key_level, bus.key_press, bus.key_release, bus.key_repeat, bus.tick_1ms} !== '0) begin
            errors++;
            $display("FAIL %s got level=%b press=%b release=%b repeat=%b tick=%b want all 0",
                     name, bus.key_level, bus.key_press, bus.key_release,
                     bus.key_repeat, bus.tick_1ms);
        end
    endtask

    task automatic do_reset(input int ph);
        @(negedge clk);
        mon_en    = 1'b0;
        rst       = 1'b1;
        bus.key_n = '1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        phase  = ph;
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic run_stim(input int ph);
        foreach (stim[i]) begin
            if (stim[i].ph == ph) begin
                wait_until(stim[i].cyc);
                bus.key_n = stim[i].key_n;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d phase=%0d", cyc, phase);
        $fatal(1, "timeout");
    end

    initial begin
        bus.key_n = '1;

        // 1: clean press of key 0, release accepted on the tick the first
        //    repeat would be due (edge 36)
        stim.push_back('{1,   2, 5'b11110});
        stim.push_back('{1,  22, 5'b11111});
        // 3: key 2 held ~60 ticks
        stim.push_back('{3,   2, 5'b11011});
        stim.push_back('{3, 242, 5'b11111});
        // 4: keys 3 and 4 together; release also lands on a due repeat (68)
        stim.push_back('{4,   2, 5'b00111});
        stim.push_back('{4,  54, 5'b11111});
        // 5: key 0 held into REPEAT, then reset mid-operation
        stim.push_back('{5,   2, 5'b11110});

        evs.push_back('{1,  16, 5'b00001, 5'b00000, 5'b00000,  1, 0});
        evs.push_back('{1,  36, 5'b00000, 5'b00001, 5'b00000,  1, 0});
        evs.push_back('{2,  56, 5'b00010, 5'b00000, 5'b00000,  1, 0});
        evs.push_back('{3,  16, 5'b00100, 5'b00000, 5'b00000,  1, 0});
        evs.push_back('{3,  36, 5'b00000, 5'b00000, 5'b00100, 28, 8});
        evs.push_back('{3, 256, 5'b00000, 5'b00100, 5'b00000,  1, 0});
        evs.push_back('{4,  16, 5'b11000, 5'b00000, 5'b00000,  1, 0});
        evs.push_back('{4,  36, 5'b00000, 5'b00000, 5'b11000,  4, 8});
        evs.push_back('{4,  68, 5'b00000, 5'b11000, 5'b00000,  1, 0});
        evs.push_back('{5,  16, 5'b00001, 5'b00000, 5'b00000,  1, 0});
        evs.push_back('{5,  36, 5'b00000, 5'b00000, 5'b00001,  2, 8});
        evs.push_back('{6,  12, 5'b00001, 5'b00000, 5'b00000,  1, 0});
        evs.push_back('{6,  32, 5'b00000, 5'b00000, 5'b00001,  2, 8});

        lvls.push_back('{1,  15, 5'b00000});
        lvls.push_back('{1,  16, 5'b00001});
        lvls.push_back('{1,  35, 5'b00001});
        lvls.push_back('{1,  36, 5'b00000});
        lvls.push_back('{2,  55, 5'b00000});
        lvls.push_back('{2,  56, 5'b00010});
        lvls.push_back('{3, 255, 5'b00100});
        lvls.push_back('{3, 256, 5'b00000});
        lvls.push_back('{4,  16, 5'b11000});
        lvls.push_back('{4,  67, 5'b11000});
        lvls.push_back('{4,  68, 5'b00000});
        lvls.push_back('{5,  46, 5'b00001});
        lvls.push_back('{6,  11, 5'b00000});
        lvls.push_back('{6,  12, 5'b00001});

        do_reset(1);
        run_stim(1);
        wait_until(60);

        // 2: key 1 bounces with 3-cycle phases, last edge (low) at cycle 44
        do_reset(2);
        for (int j = 0; j <= 14; j++) begin
            wait_until(2 + 3 * j);
            bus.key_n[1] = ((j % 2) == 1);
        end
        wait_until(70);

        do_reset(3);
        run_stim(3);
        wait_until(290);

        do_reset(4);
        run_stim(4);
        wait_until(80);

        do_reset(5);
        run_stim(5);
        wait_until(46);
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_all_zero("mid_reset_clear");
        repeat (2) @(negedge clk);
        phase  = 6;
        rst    = 1'b0;
        mon_en = 1'b1;
        wait_until(44);

        @(negedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
